// File: rtl/mem_scan_reader.sv
// Scans a 32x4 synchronous memory from start_addr up to address 31, presenting each
// word on a valid/ready port and advancing either on an internal tick or a step pulse.
module mem_scan_reader #(
   parameter int TICK_DIV = 25000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       stop,
   input  logic       step,
   input  logic       auto_mode,
   input  logic [4:0] start_addr,
   output logic [4:0] mem_addr,
   output logic       mem_rd,
   input  logic [3:0] mem_data,
   output logic [4:0] out_addr,
   output logic [3:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       busy,
   output logic       done
);

   localparam int            TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ISSUE = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_HOLD  = 3'd3;
   localparam logic [2:0] S_PACE  = 3'd4;

   logic [2:0]    state_q, state_d;
   logic [4:0]    addr_q, addr_d;
   logic [TW-1:0] tick_q, tick_d;
   logic [4:0]    out_addr_q, out_addr_d;
   logic [3:0]    out_data_q, out_data_d;
   logic          out_valid_q, out_valid_d;
   logic          done_q, done_d;

   always_comb begin
      // NOTE: every variable gets a default first so no path through the case infers a latch.
      state_d     = state_q;
      addr_d      = addr_q;
      tick_d      = tick_q;
      out_addr_d  = out_addr_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      done_d      = 1'b0;

      // stop outranks everything else, including a handshake completing in the same cycle.
      if (stop) begin
         state_d     = S_IDLE;
         out_valid_d = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  addr_d  = start_addr;
                  state_d = S_ISSUE;
               end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
               out_data_d  = mem_data;
               out_addr_d  = addr_q;
               out_valid_d = 1'b1;
               state_d     = S_HOLD;
            end
            S_HOLD: begin
               if (out_valid_q && out_ready) begin
                  out_valid_d = 1'b0;
                  if (addr_q == 5'd31) begin
                     done_d  = 1'b1;
                     state_d = S_IDLE;
                  end else begin
                     tick_d  = '0;
                     state_d = S_PACE;
                  end
               end
            end
            S_PACE: begin
               // Counter only runs in auto mode so a mode flip mid-PACE resumes the count.
               if (auto_mode) begin
                  if (tick_q == TICK_MAX) begin
                     addr_d  = addr_q + 5'd1;
                     state_d = S_ISSUE;
                  end else begin
                     tick_d = tick_q + 1'b1;
                  end
               end else if (step) begin
                  addr_d  = addr_q + 5'd1;
                  state_d = S_ISSUE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         tick_q      <= '0;
         out_addr_q  <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         tick_q      <= tick_d;
         out_addr_q  <= out_addr_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         done_q      <= done_d;
      end
   end

   assign mem_addr  = addr_q;
   assign mem_rd    = (state_q == S_ISSUE);
   assign busy      = (state_q != S_IDLE);
   assign out_addr  = out_addr_q;
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign done      = done_q;

endmodule
